// File: rtl/inst_queue_if.sv
// rtl/inst_queue_if.sv - fetch/issue handshake bundle between fetch, inst_queue and cur_inst
interface inst_queue_if #(
  parameter int ADDR_W = 3
);
  logic              in_valid;
  logic [31:0]       in_instr;
  logic              out_ready;
  logic [3:0]        in_ICC_flags;
  logic              in_fetch_req;
  logic              out_fetch_next;
  logic [5:0]        out_operator_type;
  logic [4:0]        out_reg_1;
  logic [4:0]        out_reg_2;
  logic [4:0]        out_reg_3;
  logic [3:0]        out_ICC_flags;
  logic [ADDR_W:0]   out_count;
  logic              out_drop;

  modport master (
    output in_valid, in_instr, in_ICC_flags, in_fetch_req,
    input  out_ready, out_fetch_next, out_operator_type, out_reg_1, out_reg_2,
           out_reg_3, out_ICC_flags, out_count, out_drop
  );

  modport slave (
    input  in_valid, in_instr, in_ICC_flags, in_fetch_req,
    output out_ready, out_fetch_next, out_operator_type, out_reg_1, out_reg_2,
           out_reg_3, out_ICC_flags, out_count, out_drop
  );
endinterface

// File: rtl/inst_queue.sv
// rtl/inst_queue.sv - decoded SPARC format-3 instruction FIFO feeding cur_inst
// Optional INST_QUEUE_BYPASS_EN: forward a push straight to the fields when a request waits on an empty queue.
module inst_queue #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic          clk,
  input  logic          rst,
  inst_queue_if.slave   bus
);
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ISSUE} state_t;

  // entry packing: {op3[20:15], rs1[14:10], rs2[9:5], rd[4:0]}
  logic [20:0]       r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_count;
  logic              r_prev_req;
  logic              r_drop;
  state_t            r_state;
  logic [5:0]        r_op3;
  logic [4:0]        r_rs1;
  logic [4:0]        r_rs2;
  logic [4:0]        r_rd;
  logic [3:0]        r_flags;

  state_t            w_next;
  logic              w_full;
  logic              w_empty;
  logic              w_fmt3;
  logic              w_push;
  logic              w_wr_en;
  logic              w_pop;
  logic              w_bypass;
  logic              w_issue;
  logic              w_req_edge;
  logic [20:0]       w_entry;
  logic [20:0]       w_issue_entry;

  assign w_full     = (r_count == (ADDR_W+1)'(DEPTH));
  assign w_empty    = (r_count == '0);
  assign w_fmt3     = (bus.in_instr[31:30] == 2'b10);
  assign w_push     = bus.in_valid & ~w_full & w_fmt3;
  assign w_req_edge = bus.in_fetch_req & ~r_prev_req;
  assign w_entry    = {bus.in_instr[24:19], bus.in_instr[18:14],
                       bus.in_instr[4:0], bus.in_instr[29:25]};

  always_comb begin
    w_next   = r_state;
    w_pop    = 1'b0;
    w_bypass = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_req_edge) begin
          if (!w_empty) begin
            w_next = S_ISSUE;
            w_pop  = 1'b1;
          end else begin
            w_next = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        // further request edges here fold into the one already pending
        if (!w_empty) begin
          w_next = S_ISSUE;
          w_pop  = 1'b1;
        end
`ifdef INST_QUEUE_BYPASS_EN
        else if (w_push) begin
          w_next   = S_ISSUE;
          w_bypass = 1'b1;
        end
`else
        else begin
          w_next = S_WAIT;
        end
`endif
      end
      S_ISSUE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  assign w_issue       = (w_next == S_ISSUE);
  assign w_wr_en       = w_push & ~w_bypass;
  assign w_issue_entry = w_bypass ? w_entry : r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[r_wr_ptr] <= w_entry;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_prev_req <= 1'b0;
      r_drop     <= 1'b0;
      r_op3      <= '0;
      r_rs1      <= '0;
      r_rs2      <= '0;
      r_rd       <= '0;
      r_flags    <= '0;
    end else begin
      r_state    <= w_next;
      r_prev_req <= bus.in_fetch_req;
      r_drop     <= bus.in_valid & ~w_full & ~w_fmt3;
      if (w_wr_en) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_wr_en, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      // fields are loaded on the edge entering ISSUE so they line up with the strobe
      if (w_issue) begin
        r_op3   <= w_issue_entry[20:15];
        r_rs1   <= w_issue_entry[14:10];
        r_rs2   <= w_issue_entry[9:5];
        r_rd    <= w_issue_entry[4:0];
        r_flags <= bus.in_ICC_flags;
      end
    end
  end

  assign bus.out_ready         = ~w_full;
  assign bus.out_fetch_next    = (r_state == S_ISSUE);
  assign bus.out_operator_type = r_op3;
  assign bus.out_reg_1         = r_rs1;
  assign bus.out_reg_2         = r_rs2;
  assign bus.out_reg_3         = r_rd;
  assign bus.out_ICC_flags     = r_flags;
  assign bus.out_count         = r_count;
  assign bus.out_drop          = r_drop;
endmodule

// File: tb/tb_inst_queue.sv
// tb/tb_inst_queue.sv - randomized scoreboard bench for inst_queue against a queue-based model
module tb_inst_queue;
  localparam int DEPTH  = 8;
  localparam int ADDR_W = 3;

  typedef struct {
    logic [5:0] op3;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic [3:0] flags;
  } issue_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  inst_queue_if #(.ADDR_W(ADDR_W)) bus ();
  inst_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_vec = 0;
  int n_err = 0;

  // model state, always describing the cycle after the most recent posedge
  issue_t mq[$];
  issue_t sb[$];
  logic   m_prev, m_wait, m_strobe, m_drop, m_after_rst, m_active;
  issue_t held;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic issue_t dec(input logic [31:0] w, input logic [3:0] f);
    issue_t e;
    e.op3 = w[24:19]; e.rs1 = w[18:14]; e.rs2 = w[4:0]; e.rd = w[29:25]; e.flags = f;
    return e;
  endfunction

  task automatic do_reset();
    @(negedge clk); #1;
    rst = 1'b1; bus.in_valid = 1'b0; bus.in_fetch_req = 1'b0;
    mq.delete(); sb.delete();
    m_prev = 1'b0; m_wait = 1'b0; m_strobe = 1'b0; m_drop = 1'b0; m_after_rst = 1'b1;
    m_active = 1'b1;
  endtask

  task automatic step(input logic v, input logic [31:0] w, input logic r);
    logic [3:0] f;
    logic edge_r, ready, fmt3, push, fire, byp;
    issue_t e;
    @(negedge clk); #1;
    f = 4'($urandom_range(0, 15));
    rst = 1'b0; bus.in_valid = v; bus.in_instr = w; bus.in_fetch_req = r; bus.in_ICC_flags = f;
    edge_r = r & ~m_prev;
    ready  = (mq.size() < DEPTH);
    fmt3   = (w[31:30] == 2'b10);
    push   = v & ready & fmt3;
    fire = 1'b0; byp = 1'b0;
    if (!m_strobe) begin
      if (m_wait) begin
        if (mq.size() > 0) fire = 1'b1;
`ifdef INST_QUEUE_BYPASS_EN
        else if (push) begin fire = 1'b1; byp = 1'b1; end
`endif
      end else if (edge_r) begin
        if (mq.size() > 0) fire = 1'b1;
        else m_wait = 1'b1;
      end
    end
    if (fire) begin
      e = byp ? dec(w, f) : mq.pop_front();
      e.flags = f;
      sb.push_back(e);
      m_wait = 1'b0;
    end
    if (push && !byp) mq.push_back(dec(w, 4'h0));
    m_drop = v & ready & ~fmt3;
    m_strobe = fire;
    m_prev = r;
    m_after_rst = 1'b0;
  endtask

  function automatic logic [31:0] rnd_fmt3();
    logic [31:0] x;
    x = $urandom();
    x[31:30] = 2'b10;
    return x;
  endfunction

  always @(negedge clk) begin
    if (m_active) begin
      if (m_after_rst) begin
        held = '{default: '0};
        chk("reset_count", 32'(bus.out_count), 0);
        chk("reset_ready", 32'(bus.out_ready), 1);
      end
      chk("count", 32'(bus.out_count), 32'(mq.size()));
      chk("ready", 32'(bus.out_ready), 32'(mq.size() < DEPTH));
      chk("drop", 32'(bus.out_drop), 32'(m_drop));
      chk("strobe", 32'(bus.out_fetch_next), 32'(m_strobe));
      if (bus.out_fetch_next === 1'b1) begin
        if (sb.size() == 0) begin
          chk("unexpected_strobe", 32'(1), 32'(0));
        end else begin
          held = sb.pop_front();
        end
      end
      chk("op3", 32'(bus.out_operator_type), 32'(held.op3));
      chk("rs1", 32'(bus.out_reg_1), 32'(held.rs1));
      chk("rs2", 32'(bus.out_reg_2), 32'(held.rs2));
      chk("rd", 32'(bus.out_reg_3), 32'(held.rd));
      chk("icc", 32'(bus.out_ICC_flags), 32'(held.flags));
    end
  end

  initial begin
    logic r_lvl;
    m_active = 1'b0; m_after_rst = 1'b0;
    rst = 1'b1; bus.in_valid = 1'b0; bus.in_instr = '0; bus.in_fetch_req = 1'b0; bus.in_ICC_flags = '0;
    do_reset();

    step(1, 32'h85286001, 0);
    step(0, 0, 1); step(0, 0, 0); step(0, 0, 0); step(0, 0, 0);

    step(1, 32'h45286001, 0);
    step(0, 0, 1); step(0, 0, 0); step(0, 0, 0);

    for (int i = 0; i < DEPTH + 1; i++) step(1, rnd_fmt3(), 0);
    step(1, rnd_fmt3(), 0);
    step(0, 0, 1); step(0, 0, 0); step(0, 0, 0);

    for (int i = 0; i < 2 * DEPTH; i++) step(1, rnd_fmt3(), i[0] == 1'b0);
    for (int i = 0; i < 2 * DEPTH; i++) step(0, 0, i[0] == 1'b0);
    step(0, 0, 0);

    step(0, 0, 1); step(0, 0, 0); step(0, 0, 1); step(0, 0, 0);
    step(1, 32'h84004002, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0);

    for (int i = 0; i < 3; i++) step(1, rnd_fmt3(), 0);
    do_reset();
    step(0, 0, 1); step(0, 0, 0); step(0, 0, 0); step(0, 0, 0);
    step(1, rnd_fmt3(), 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0);

    r_lvl = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      logic [31:0] w;
      w = ($urandom_range(0, 99) < 85) ? rnd_fmt3() : $urandom();
      if ($urandom_range(0, 99) < 40) r_lvl = ~r_lvl;
      step($urandom_range(0, 1) == 1, w, r_lvl);
    end

    for (int i = 0; i < 3 * DEPTH; i++) step(0, 0, i[0] == 1'b0);
    step(0, 0, 0); step(0, 0, 0);
    @(negedge clk); #1;
    chk("scoreboard_drained", 32'(sb.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
